// File: rtl/hack_seq_ctrl.sv
// Fetch/execute sequencer for the Hack CPU: owns PC and IR, runs the ROM and
// data-memory handshakes, drives A/D load strobes and resolves jumps.
module hack_seq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic [14:0] rom_addr,
   output logic        fetch_req,
   output logic [15:0] ir,
   input  logic        zr,
   input  logic        ng,
   input  logic [15:0] a_reg,
   output logic        a_load,
   output logic        a_sel,
   output logic        d_load,
   output logic        m_write,
   input  logic        m_ack,
   output logic [14:0] pc,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_UPDATE = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t      r_state;
   logic [14:0] r_pc;
   logic [14:0] r_target;
   logic [15:0] r_ir;
   logic        r_halted;
   logic        r_take_jump;

   logic        w_exec;
   logic        w_is_c;
   logic        w_commit;
   logic        w_unused;

   function automatic logic jump_cond(input logic [2:0] j, input logic z, input logic n);
      logic res;
      case (j)
         3'd0:    res = 1'b0;
         3'd1:    res = !z && !n;
         3'd2:    res = z;
         3'd3:    res = z || !n;
         3'd4:    res = n;
         3'd5:    res = !z;
         3'd6:    res = z || n;
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   // Strobes are gated by reset so nothing fires while reset is held mid-handshake.
   assign w_exec   = (r_state == S_EXEC) && !reset;
   assign w_is_c   = r_ir[15];
   assign w_commit = w_exec && (!r_ir[3] || m_ack);
   assign w_unused = a_reg[15];

   assign rom_addr  = r_pc;
   assign pc        = r_pc;
   assign ir        = r_ir;
   assign halted    = r_halted;
   assign fetch_req = (r_state == S_FETCH) && !reset;
   assign a_load    = w_exec && (w_is_c ? (w_commit && r_ir[5]) : 1'b1);
   assign a_sel     = w_exec && w_is_c && w_commit;
   assign d_load    = w_exec && w_is_c && w_commit && r_ir[4];
   assign m_write   = w_exec && w_is_c && r_ir[3];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_ir        <= '0;
         r_halted    <= 1'b0;
         r_take_jump <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               if (instr_valid) begin
                  r_ir    <= instr;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!w_is_c) begin
                  r_take_jump <= 1'b0;
                  r_state     <= S_UPDATE;
               end else if (w_commit) begin
                  // Target is the A value before this edge's load takes effect.
                  r_take_jump <= jump_cond(r_ir[2:0], zr, ng);
                  r_target    <= a_reg[14:0];
                  r_state     <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (r_take_jump) begin
                  r_pc <= r_target;
               end else begin
                  r_pc <= r_pc + 15'd1;
               end
               if (r_take_jump && (r_target == r_pc)) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
